// File: rtl/adder_share_pkg.sv
// ---------------------------------------------------------------------------
// adder_share_pkg
// Shared constants and types for the adder-sharing arbiter.
//   NREQ_DEF / WIDTH_DEF / IDW_DEF : default requester count, operand width
//                                    and requester index width
//   req_idx_t                      : requester index type at the defaults
//   OP_ADD / OP_SUB                : value of req_sub selecting add or sub
// ---------------------------------------------------------------------------
package adder_share_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 32;
    localparam int IDW_DEF   = 2;

    typedef logic [IDW_DEF-1:0] req_idx_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_add32.sv
// ---------------------------------------------------------------------------
// cla_add32
// Carry-lookahead adder built from 4-bit lookahead groups. Each group forms
// its internal carries directly from P/G terms and hands a group carry to
// the next group through its group propagate/generate pair.
// Ports:
//   a_i, b_i  : operands (WIDTH bits, WIDTH a multiple of 4)
//   cin_i     : carry into bit 0
//   sum_o     : sum
//   cout_o    : carry out of the MSB
// ---------------------------------------------------------------------------
module cla_add32
    import adder_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] bitP;
    logic [WIDTH-1:0] bitG;
    logic [WIDTH:0]   carry;
    logic [NGRP-1:0]  grpP;
    logic [NGRP-1:0]  grpG;

    // Per-group lookahead: the three inner carries are expanded from the
    // group's incoming carry, and the group P/G produce the next group carry.
    always_comb begin
        bitP     = a_i ^ b_i;
        bitG     = a_i & b_i;
        carry    = '0;
        grpP     = '0;
        grpG     = '0;
        carry[0] = cin_i;
        for (int k = 0; k < NGRP; k++) begin
            carry[4*k+1] = bitG[4*k]
                         | (bitP[4*k] & carry[4*k]);
            carry[4*k+2] = bitG[4*k+1]
                         | (bitP[4*k+1] & bitG[4*k])
                         | (bitP[4*k+1] & bitP[4*k] & carry[4*k]);
            carry[4*k+3] = bitG[4*k+2]
                         | (bitP[4*k+2] & bitG[4*k+1])
                         | (bitP[4*k+2] & bitP[4*k+1] & bitG[4*k])
                         | (bitP[4*k+2] & bitP[4*k+1] & bitP[4*k] & carry[4*k]);
            grpG[k]      = bitG[4*k+3]
                         | (bitP[4*k+3] & bitG[4*k+2])
                         | (bitP[4*k+3] & bitP[4*k+2] & bitG[4*k+1])
                         | (bitP[4*k+3] & bitP[4*k+2] & bitP[4*k+1] & bitG[4*k]);
            grpP[k]      = &bitP[4*k +: 4];
            carry[4*k+4] = grpG[k] | (grpP[k] & carry[4*k]);
        end
    end

    assign sum_o  = bitP ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
// Round-robin arbiter that shares one carry-lookahead adder among NREQ
// requesters and captures each result in a single-entry output register
// with a valid/ready handshake (drain and refill in the same cycle).
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready : per-requester handshake, ready is one-hot
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             : 1 = A-B, 0 = A+B
//   req_lock            : (ADDER_SHARE_LOCK_EN only) hold the grant for the
//                         next transfer of the same requester
//   resp_valid/ready    : result handshake
//   resp_id, resp_sum   : owner index and sum/difference
//   resp_cout, resp_ovf : carry out of MSB, signed overflow
//   busy                : result pending but not being accepted
// Optional feature macro: ADDER_SHARE_LOCK_EN
// ---------------------------------------------------------------------------
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = IDW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
`ifdef ADDER_SHARE_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  resp_cout,
    output logic                  resp_ovf,
    output logic                  busy
);

    logic             respValid_q, respValid_d;
    logic [IDW-1:0]   respId_q,    respId_d;
    logic [WIDTH-1:0] respSum_q,   respSum_d;
    logic             respCout_q,  respCout_d;
    logic             respOvf_q,   respOvf_d;
    logic [IDW-1:0]   rrPtr_q,     rrPtr_d;
`ifdef ADDER_SHARE_LOCK_EN
    logic             locked_q,    locked_d;
    logic [IDW-1:0]   lockOwner_q, lockOwner_d;
`endif

    logic             canIssue;
    logic             grantValid;
    logic [IDW-1:0]   grantIdx;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic [WIDTH-1:0] bEff;
    logic             selSub;
    logic [WIDTH-1:0] addSum;
    logic             addCout;
    logic             addOvf;

    // Index arithmetic modulo NREQ, which need not be a power of two.
    function automatic logic [IDW-1:0] wrapIdx(input int base, input int off);
        int t;
        t = base + off;
        if (t >= NREQ) t = t - NREQ;
        return IDW'(t);
    endfunction

    // Grant selection: the slot is free when empty or draining this cycle.
    // The search runs from the highest offset down so the first valid
    // requester at or after rrPtr_q is the one left standing. Reset masks
    // every grant so no requester sees a spurious accept.
    always_comb begin
        canIssue   = !respValid_q || resp_ready;
        grantValid = 1'b0;
        grantIdx   = '0;
        req_ready  = '0;
        if (canIssue && !rst) begin
`ifdef ADDER_SHARE_LOCK_EN
            if (locked_q) begin
                if (req_valid[lockOwner_q]) begin
                    grantValid = 1'b1;
                    grantIdx   = lockOwner_q;
                end
            end else
`endif
            begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid[wrapIdx(int'(rrPtr_q), k)]) begin
                        grantValid = 1'b1;
                        grantIdx   = wrapIdx(int'(rrPtr_q), k);
                    end
                end
            end
            req_ready[grantIdx] = grantValid;
        end
    end

    // Operand mux into the single shared adder; subtraction inverts B and
    // feeds a carry-in of one.
    always_comb begin
        selA   = req_a[grantIdx*WIDTH +: WIDTH];
        selB   = req_b[grantIdx*WIDTH +: WIDTH];
        selSub = (req_sub[grantIdx] == OP_SUB);
        bEff   = selSub ? ~selB : selB;
    end

    cla_add32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (selA),
        .b_i    (bEff),
        .cin_i  (selSub),
        .sum_o  (addSum),
        .cout_o (addCout)
    );

    assign addOvf = (selA[WIDTH-1] == bEff[WIDTH-1]) && (addSum[WIDTH-1] != selA[WIDTH-1]);

    // Next-state: a transfer loads the result register and moves the
    // pointer past the winner; otherwise an accepted result simply drains.
    // While locked the pointer stays put so the rotation resumes where it
    // left off once the owner releases.
    always_comb begin
        respValid_d = respValid_q;
        respId_d    = respId_q;
        respSum_d   = respSum_q;
        respCout_d  = respCout_q;
        respOvf_d   = respOvf_q;
        rrPtr_d     = rrPtr_q;
`ifdef ADDER_SHARE_LOCK_EN
        locked_d    = locked_q;
        lockOwner_d = lockOwner_q;
`endif
        if (grantValid) begin
            respValid_d = 1'b1;
            respId_d    = grantIdx;
            respSum_d   = addSum;
            respCout_d  = addCout;
            respOvf_d   = addOvf;
`ifdef ADDER_SHARE_LOCK_EN
            if (!locked_q) rrPtr_d = wrapIdx(int'(grantIdx), 1);
            if (req_lock[grantIdx]) begin
                locked_d    = 1'b1;
                lockOwner_d = grantIdx;
            end else begin
                locked_d    = 1'b0;
            end
`else
            rrPtr_d     = wrapIdx(int'(grantIdx), 1);
`endif
        end else if (resp_ready) begin
            respValid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            respValid_q <= 1'b0;
            respId_q    <= '0;
            respSum_q   <= '0;
            respCout_q  <= 1'b0;
            respOvf_q   <= 1'b0;
            rrPtr_q     <= '0;
`ifdef ADDER_SHARE_LOCK_EN
            locked_q    <= 1'b0;
            lockOwner_q <= '0;
`endif
        end else begin
            respValid_q <= respValid_d;
            respId_q    <= respId_d;
            respSum_q   <= respSum_d;
            respCout_q  <= respCout_d;
            respOvf_q   <= respOvf_d;
            rrPtr_q     <= rrPtr_d;
`ifdef ADDER_SHARE_LOCK_EN
            locked_q    <= locked_d;
            lockOwner_q <= lockOwner_d;
`endif
        end
    end

    assign resp_valid = respValid_q;
    assign resp_id    = respId_q;
    assign resp_sum   = respSum_q;
    assign resp_cout  = respCout_q;
    assign resp_ovf   = respOvf_q;
    assign busy       = respValid_q && !resp_ready;

endmodule
